// File: rtl/alu_pkg.sv
// Shared ALU definitions.
// Purpose : ALU control codes, MIPS R-type funct codes and the sequencer
//           FSM state type, imported by the sequencer and the funct decoder.
// Ports   : none (package).
package alu_pkg;

    // ALUControl encodings understood by the clocked ALU.
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_MUL = 4'b0010;
    localparam logic [3:0] ALU_DIV = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_AND = 4'b1000;
    localparam logic [3:0] ALU_OR  = 4'b1001;
    localparam logic [3:0] ALU_XOR = 4'b1010;
    localparam logic [3:0] ALU_NOR = 4'b1011;

    // MIPS R-type funct field values.
    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_MULT = 6'h18;
    localparam logic [5:0] FUNCT_DIV  = 6'h1A;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_t;

    // Width of a down-counter able to hold the larger of two latencies.
    function automatic int unsigned lat_width(input int unsigned mul_cycles,
                                              input int unsigned div_cycles);
        int unsigned m;
        m = (mul_cycles > div_cycles) ? mul_cycles : div_cycles;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/alu_funct_decode.sv
// MIPS funct decoder.
// Purpose : combinational translation of an R-type funct code into the
//           ALU control code, the number of ALU cycles the operation needs,
//           and an illegal flag for unsupported codes.
// Ports   : funct   in  6   MIPS R-type funct field
//           ctrl    out 4   ALUControl code (0 when illegal)
//           lat     out CW  ALU latency in cycles (0 when illegal)
//           illegal out 1   funct is not supported
module alu_funct_decode
    import alu_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CW         = lat_width(MUL_CYCLES, DIV_CYCLES)
) (
    input  logic [5:0]    funct,
    output logic [3:0]    ctrl,
    output logic [CW-1:0] lat,
    output logic          illegal
);

    localparam logic [CW-1:0] LAT_ONE = CW'(1);
    localparam logic [CW-1:0] LAT_MUL = CW'(MUL_CYCLES);
    localparam logic [CW-1:0] LAT_DIV = CW'(DIV_CYCLES);

    always_comb begin
        ctrl    = ALU_ADD;
        lat     = LAT_ONE;
        illegal = 1'b0;
        case (funct)
            FUNCT_ADD,
            FUNCT_ADDU: ctrl = ALU_ADD;
            FUNCT_SUB,
            FUNCT_SUBU: ctrl = ALU_SUB;
            FUNCT_MULT: begin
                ctrl = ALU_MUL;
                lat  = LAT_MUL;
            end
            FUNCT_DIV: begin
                ctrl = ALU_DIV;
                lat  = LAT_DIV;
            end
            FUNCT_SLL:  ctrl = ALU_SLL;
            FUNCT_SRL:  ctrl = ALU_SRL;
            FUNCT_AND:  ctrl = ALU_AND;
            FUNCT_OR:   ctrl = ALU_OR;
            FUNCT_XOR:  ctrl = ALU_XOR;
            FUNCT_NOR:  ctrl = ALU_NOR;
            default: begin
                ctrl    = '0;
                lat     = '0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// ALU issue sequencer.
// Purpose : accepts one R-type operation at a time on a valid/ready request
//           channel, decodes funct to ALUControl, holds the ALU inputs stable
//           for the operation's latency, captures ALUOut/Zero and returns
//           them on a valid/ready response channel. Illegal functs and
//           divide-by-zero are answered immediately without touching the ALU.
// Ports   : clk, reset              clock (rising edge), async active-high reset
//           req_valid/req_ready     request handshake
//           req_funct/a/b/shamt     request payload
//           alu_a/b/ctrl/shamt      registered ALU inputs
//           alu_out/alu_zero        ALU results
//           rsp_valid/rsp_ready     response handshake
//           rsp_result/zero         captured ALU result and Zero flag
//           rsp_illegal/rsp_divz    error flags
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_funct,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_shamt,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_illegal,
    output logic        rsp_divz
);

    localparam int unsigned CW = lat_width(MUL_CYCLES, DIV_CYCLES);

    seq_state_t    state;
    logic [CW-1:0] cnt;

    logic [3:0]    dec_ctrl;
    logic [CW-1:0] dec_lat;
    logic          dec_illegal;
    logic          dec_divz;

    alu_funct_decode #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CW         (CW)
    ) u_decode (
        .funct   (req_funct),
        .ctrl    (dec_ctrl),
        .lat     (dec_lat),
        .illegal (dec_illegal)
    );

    assign dec_divz = (dec_ctrl == ALU_DIV) && !dec_illegal && (req_b == '0);

    // Handshake flags are pure decodes of the state register.
    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_ctrl    <= '0;
            alu_shamt   <= '0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
            rsp_divz    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (dec_illegal) begin
                            rsp_result  <= '0;
                            rsp_zero    <= 1'b0;
                            rsp_illegal <= 1'b1;
                            rsp_divz    <= 1'b0;
                            state       <= ST_RESP;
                        end else if (dec_divz) begin
                            rsp_result  <= '0;
                            rsp_zero    <= 1'b0;
                            rsp_illegal <= 1'b0;
                            rsp_divz    <= 1'b1;
                            state       <= ST_RESP;
                        end else begin
                            alu_a     <= req_a;
                            alu_b     <= req_b;
                            alu_ctrl  <= dec_ctrl;
                            alu_shamt <= req_shamt;
                            cnt       <= dec_lat;
                            state     <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    // Counter runs LAT..0, so capture lands LAT+1 edges
                    // after acceptance; it stops at zero and never wraps.
                    if (cnt == '0) begin
                        rsp_result  <= alu_out;
                        rsp_zero    <= alu_zero;
                        rsp_illegal <= 1'b0;
                        rsp_divz    <= 1'b0;
                        state       <= ST_RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
